pixel_write_arbiter: RTL and testbench



---
 rtl/pixel_arb_pkg.sv | 33 +++
 rtl/pixel_write_arbiter_fifo.sv | 60 ++++++
 rtl/pixel_write_arbiter.sv | 177 +++++++++++++++++
 tb/tb_pixel_write_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_arb_pkg.sv
// Shared widths, default visible-area limits, the pixel record and the
// round-robin index helper for the pixel write arbiter.
package pixel_arb_pkg;

    localparam int X_W_DEF   = 8;
    localparam int Y_W_DEF   = 8;
    localparam int C_W_DEF   = 3;
    localparam int H_PIX_DEF = 200;
    localparam int V_PIX_DEF = 150;

    // Wide enough to index up to 8 sources.
    localparam int IDX_W = 3;

    typedef struct packed {
        logic [X_W_DEF-1:0] x;
        logic [Y_W_DEF-1:0] y;
        logic [C_W_DEF-1:0] r;
        logic [C_W_DEF-1:0] g;
        logic [C_W_DEF-1:0] b;
    } pixel_t;

    // Next source index after idx, wrapping at n_src.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                                 input int unsigned     n_src);
        logic [IDX_W:0] inc;
        inc = {1'b0, idx} + (IDX_W+1)'(1);
        if (32'(inc) >= n_src) begin
            return '0;
        end
        return inc[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/pixel_write_arbiter_fifo.sv
// Per-source pixel FIFO: power-of-two circular buffer with an occupancy count.
// Push into a full FIFO and pop from an empty one are ignored.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Round-robin merge of N_SRC pixel-write streams into the single frame-buffer
// write port. Each source has its own FIFO; the winner is loaded into one
// registered output stage with a valid/ready handshake.
// Optional feature macro: PIXEL_WRITE_ARBITER_CLIP_EN drops pixels outside the
// H_PIX x V_PIX visible area at arbitration time and counts them.
module pixel_write_arbiter
    import pixel_arb_pkg::*;
#(
    parameter int N_SRC = 2,
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int C_W   = C_W_DEF,
    parameter int DEPTH = 4,
    parameter int H_PIX = H_PIX_DEF,
    parameter int V_PIX = V_PIX_DEF,
    localparam int SW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     src_valid,
    output logic [N_SRC-1:0]     src_ready,
    input  logic [N_SRC*X_W-1:0] src_x,
    input  logic [N_SRC*Y_W-1:0] src_y,
    input  logic [N_SRC*C_W-1:0] src_r,
    input  logic [N_SRC*C_W-1:0] src_g,
    input  logic [N_SRC*C_W-1:0] src_b,
    output logic                 write_en,
    input  logic                 write_ready,
    output logic [X_W-1:0]       write_x,
    output logic [Y_W-1:0]       write_y,
    output logic [C_W-1:0]       write_r,
    output logic [C_W-1:0]       write_g,
    output logic [C_W-1:0]       write_b,
    output logic [SW-1:0]        write_src,
    output logic [15:0]          clip_count
);

    localparam int DW = X_W + Y_W + 3*C_W;

    logic [N_SRC-1:0] fifo_push;
    logic [N_SRC-1:0] fifo_pop;
    logic [N_SRC-1:0] fifo_full;
    logic [N_SRC-1:0] fifo_empty;
    logic [DW-1:0]    fifo_din  [N_SRC];
    logic [DW-1:0]    fifo_dout [N_SRC];

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] sel;
    logic             found;
    logic [DW-1:0]    sel_data;
    logic             out_free;
    logic             load_go;
    logic             clip_hit;

    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [C_W-1:0]   sel_r;
    logic [C_W-1:0]   sel_g;
    logic [C_W-1:0]   sel_b;

    // Ready depends only on own occupancy: a full FIFO stays not-ready even
    // in a cycle where it is being popped.
    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign src_ready[g] = !fifo_full[g] && !reset;
        assign fifo_push[g] = src_valid[g] && src_ready[g];
        assign fifo_din[g]  = {src_x[g*X_W +: X_W], src_y[g*Y_W +: Y_W],
                               src_r[g*C_W +: C_W], src_g[g*C_W +: C_W],
                               src_b[g*C_W +: C_W]};

        pixel_fifo #(
            .DEPTH (DEPTH),
            .DW    (DW)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (fifo_push[g]),
            .pop   (fifo_pop[g]),
            .din   (fifo_din[g]),
            .dout  (fifo_dout[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    assign out_free = !write_en || write_ready;
    assign load_go  = out_free && found;

    // Round-robin search over non-empty FIFOs starting after last_grant.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = rr_next(last_grant, N_SRC);
        for (int k = 0; k < N_SRC; k++) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (!found && scan_idx == IDX_W'(i) && !fifo_empty[i]) begin
                    found = 1'b1;
                    sel   = scan_idx;
                end
            end
            scan_idx = rr_next(scan_idx, N_SRC);
        end
    end

    // Head-of-FIFO data of the winner and the pop strobe back to its FIFO.
    always_comb begin
        sel_data = '0;
        fifo_pop = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel == IDX_W'(i)) begin
                sel_data    = fifo_dout[i];
                fifo_pop[i] = load_go;
            end
        end
    end

    assign sel_x = sel_data[DW-1 -: X_W];
    assign sel_y = sel_data[DW-X_W-1 -: Y_W];
    assign sel_r = sel_data[3*C_W-1 -: C_W];
    assign sel_g = sel_data[2*C_W-1 -: C_W];
    assign sel_b = sel_data[C_W-1:0];

`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
    // One extra bit so limits equal to 2**X_W / 2**Y_W still compare correctly.
    localparam logic [X_W:0] H_LIM = (X_W+1)'(H_PIX);
    localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_PIX);

    assign clip_hit = ({1'b0, sel_x} >= H_LIM) || ({1'b0, sel_y} >= V_LIM);

    // Saturating count of pixels discarded for lying outside the visible area.
    always_ff @(posedge clock) begin
        if (reset) begin
            clip_count <= '0;
        end else if (load_go && clip_hit && clip_count != 16'hFFFF) begin
            clip_count <= clip_count + 16'd1;
        end
    end
`else
    logic unused_clip_cfg;

    assign clip_hit        = 1'b0;
    assign clip_count      = '0;
    assign unused_clip_cfg = (H_PIX > 0) ^ (V_PIX > 0);
`endif

    // Output stage: reload whenever free; a clipped pixel leaves it empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_en   <= 1'b0;
            write_x    <= '0;
            write_y    <= '0;
            write_r    <= '0;
            write_g    <= '0;
            write_b    <= '0;
            write_src  <= '0;
            last_grant <= IDX_W'(N_SRC-1);
        end else if (out_free) begin
            if (found) begin
                last_grant <= sel;
                if (clip_hit) begin
                    write_en <= 1'b0;
                end else begin
                    write_en  <= 1'b1;
                    write_x   <= sel_x;
                    write_y   <= sel_y;
                    write_r   <= sel_r;
                    write_g   <= sel_g;
                    write_b   <= sel_b;
                    write_src <= sel[SW-1:0];
                end
            end else begin
                write_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter with four sources. A per-source
// scoreboard records every accepted pixel and checks each pixel the frame
// buffer accepts against the head of its source queue.
module tb_pixel_write_arbiter;
    import pixel_arb_pkg::*;

    localparam int N = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  src_valid = '0;
    logic [N-1:0]  src_ready;
    logic [N*8-1:0] src_x;
    logic [N*8-1:0] src_y;
    logic [N*3-1:0] src_r;
    logic [N*3-1:0] src_g;
    logic [N*3-1:0] src_b;
    logic          write_en;
    logic          write_ready = 1'b0;
    logic [7:0]    write_x;
    logic [7:0]    write_y;
    logic [2:0]    write_r;
    logic [2:0]    write_g;
    logic [2:0]    write_b;
    logic [1:0]    write_src;
    logic [15:0]   clip_count;

    pixel_t src_pix [N];
    pixel_t exp_q [N][$];

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    int seq    = 0;

    logic [N-1:0] st_push;
    logic         st_xfer;
    logic [1:0]   st_src;

    pixel_write_arbiter #(.N_SRC(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_x       (src_x),
        .src_y       (src_y),
        .src_r       (src_r),
        .src_g       (src_g),
        .src_b       (src_b),
        .write_en    (write_en),
        .write_ready (write_ready),
        .write_x     (write_x),
        .write_y     (write_y),
        .write_r     (write_r),
        .write_g     (write_g),
        .write_b     (write_b),
        .write_src   (write_src),
        .clip_count  (clip_count)
    );

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            src_x[i*8 +: 8] = src_pix[i].x;
            src_y[i*8 +: 8] = src_pix[i].y;
            src_r[i*3 +: 3] = src_pix[i].r;
            src_g[i*3 +: 3] = src_pix[i].g;
            src_b[i*3 +: 3] = src_pix[i].b;
        end
    end

    function automatic pixel_t mk(input int s, input int n);
        pixel_t p;
        p.x = 8'(n % 200);
        p.y = 8'(s*30 + n % 30);
        p.r = 3'(n);
        p.g = 3'(s);
        p.b = 3'(n / 8);
        return p;
    endfunction

    function automatic bit visible(input pixel_t p);
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
        return (int'(p.x) < H_PIX_DEF) && (int'(p.y) < V_PIX_DEF);
`else
        return 1'b1;
`endif
    endfunction

    // One clock: sample handshakes at negedge, update scoreboard, advance.
    task automatic step();
        pixel_t exp;
        @(negedge clock);
        st_push = src_valid & src_ready;
        st_xfer = write_en && write_ready;
        st_src  = write_src;
        for (int i = 0; i < N; i++) begin
            if (st_push[i] && visible(src_pix[i])) exp_q[i].push_back(src_pix[i]);
        end
        if (st_xfer) begin
            checks++;
            n_out++;
            if (exp_q[st_src].size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected pixel src=%0d x=%0d y=%0d", st_src, write_x, write_y);
            end else begin
                exp = exp_q[st_src].pop_front();
                if ({write_x, write_y, write_r, write_g, write_b} !== exp) begin
                    errors++;
                    $display("FAIL scoreboard src=%0d: got %h expected %h", st_src,
                             {write_x, write_y, write_r, write_g, write_b}, exp);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    function automatic int pending();
        int t = 0;
        for (int i = 0; i < N; i++) t += exp_q[i].size();
        return t;
    endfunction

    task automatic drain();
        int cyc = 0;
        write_ready = 1'b1;
        while (pending() != 0 && cyc < 60) begin
            step();
            cyc++;
        end
        checks++;
        if (pending() != 0) begin
            errors++;
            $display("FAIL drain timeout: %0d pixels still expected", pending());
        end
        checks++;
        if (write_en !== 1'b0) begin
            errors++;
            $display("FAIL idle after drain: write_en=%b expected 0", write_en);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({write_en, write_x, write_y, write_r, write_g, write_b, write_src, clip_count} !== '0) begin
                errors++;
                $display("FAIL reset outputs: en=%b x=%0d y=%0d src=%0d clip=%0d expected all 0",
                         write_en, write_x, write_y, write_src, clip_count);
            end
            checks++;
            if (src_ready !== 4'h0) begin
                errors++;
                $display("FAIL reset src_ready: got %b expected 0000", src_ready);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (src_ready !== 4'hF) begin
            errors++;
            $display("FAIL ready after reset: got %b expected 1111", src_ready);
        end
    endtask

    task automatic test_single();
        pixel_t p;
        p.x = 8'd5; p.y = 8'd7; p.r = 3'd3; p.g = 3'd2; p.b = 3'd1;
        write_ready = 1'b1;
        src_pix[0]  = p;
        src_valid   = 4'b0001;
        step();
        src_valid   = 4'b0000;
        checks++;
        if (write_en !== 1'b0) begin
            errors++;
            $display("FAIL single latency early: write_en=%b expected 0", write_en);
        end
        step();
        checks++;
        if ({write_en, write_x, write_y, write_r, write_g, write_b, write_src} !==
            {1'b1, 8'd5, 8'd7, 3'd3, 3'd2, 3'd1, 2'd0}) begin
            errors++;
            $display("FAIL single pixel: en=%b x=%0d y=%0d r=%0d g=%0d b=%0d src=%0d expected 1 5 7 3 2 1 0",
                     write_en, write_x, write_y, write_r, write_g, write_b, write_src);
        end
        drain();
    endtask

    task automatic test_fairness();
        int exp_g   = 0;
        bit started = 1'b0;
        write_ready = 1'b0;
        reset       = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < N; i++) src_pix[i] = mk(i, seq++);
        src_valid   = 4'hF;
        write_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            for (int i = 0; i < N; i++) if (st_push[i]) src_pix[i] = mk(i, seq++);
            if (started || st_xfer) begin
                started = 1'b1;
                checks++;
                if (!st_xfer || st_src !== 2'(exp_g)) begin
                    errors++;
                    $display("FAIL fairness cycle %0d: xfer=%b src=%0d expected xfer=1 src=%0d",
                             c, st_xfer, st_src, exp_g);
                end
                exp_g = (exp_g + 1) % N;
            end
        end
        checks++;
        if (!started) begin
            errors++;
            $display("FAIL fairness: no output seen, expected continuous stream");
        end
        src_valid = '0;
        drain();
    endtask

    task automatic test_stall();
        int npush = 0;
        int out0;
        write_ready = 1'b0;
        src_pix[1]  = mk(1, seq++);
        src_valid   = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            step();
            if (st_push[1]) begin
                npush++;
                src_pix[1] = mk(1, seq++);
            end
            if (write_en && exp_q[1].size() != 0) begin
                checks++;
                if ({write_x, write_y, write_r, write_g, write_b} !== exp_q[1][0] || write_src !== 2'd1) begin
                    errors++;
                    $display("FAIL stall hold cycle %0d: got %h src=%0d expected %h src=1", c,
                             {write_x, write_y, write_r, write_g, write_b}, write_src, exp_q[1][0]);
                end
            end
        end
        src_valid = '0;
        checks++;
        if (npush != 5) begin
            errors++;
            $display("FAIL stall accepted: got %0d pushes expected 5", npush);
        end
        checks++;
        if (src_ready[1] !== 1'b0 || write_en !== 1'b1) begin
            errors++;
            $display("FAIL stall state: src_ready1=%b write_en=%b expected 0 1", src_ready[1], write_en);
        end
        out0 = n_out;
        drain();
        checks++;
        if (n_out - out0 != 5) begin
            errors++;
            $display("FAIL stall release: got %0d pixels expected 5", n_out - out0);
        end
    endtask

    task automatic test_reset_mid();
        write_ready = 1'b0;
        src_valid   = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            src_pix[2] = mk(2, seq++);
            step();
        end
        src_valid = '0;
        reset     = 1'b1;
        step();
        for (int i = 0; i < N; i++) exp_q[i].delete();
        checks++;
        if (write_en !== 1'b0 || src_ready !== 4'h0) begin
            errors++;
            $display("FAIL reset mid: write_en=%b src_ready=%b expected 0 0000", write_en, src_ready);
        end
        reset = 1'b0;
        step();
        checks++;
        if (src_ready !== 4'hF) begin
            errors++;
            $display("FAIL reset mid ready: got %b expected 1111", src_ready);
        end
        write_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (write_en !== 1'b0) begin
                errors++;
                $display("FAIL reset mid leak cycle %0d: write_en=%b expected 0", c, write_en);
            end
        end
    endtask

    task automatic test_clip();
        pixel_t pv [3];
        int out0;
        int exp_out;
        logic [15:0] exp_clip;
        pv[0] = '{x: 8'd200, y: 8'd0,   r: 3'd1, g: 3'd1, b: 3'd1};
        pv[1] = '{x: 8'd0,   y: 8'd150, r: 3'd2, g: 3'd2, b: 3'd2};
        pv[2] = '{x: 8'd199, y: 8'd149, r: 3'd3, g: 3'd3, b: 3'd3};
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
        exp_out  = 1;
        exp_clip = 16'd2;
`else
        exp_out  = 3;
        exp_clip = 16'd0;
`endif
        out0        = n_out;
        write_ready = 1'b1;
        src_valid   = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            src_pix[3] = pv[k];
            step();
        end
        src_valid = '0;
        drain();
        step();
        checks++;
        if (n_out - out0 != exp_out) begin
            errors++;
            $display("FAIL clip written: got %0d pixels expected %0d", n_out - out0, exp_out);
        end
        checks++;
        if (clip_count !== exp_clip) begin
            errors++;
            $display("FAIL clip count: got %0d expected %0d", clip_count, exp_clip);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) src_pix[i] = '0;
        test_reset();
        test_single();
        test_fairness();
        test_stall();
        test_reset_mid();
        test_clip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
